// File: rtl/seq_det_ctrl_pkg.sv
// seq_det_ctrl_pkg: shared FSM/detector encodings and the searched pattern
package seq_det_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {START, S1, S10, S101, S1011} det_t;
  localparam logic [3:0] PATTERN = 4'b1011;
  // Each state names the longest suffix of the stream that is a pattern prefix
  function automatic det_t det_next(det_t s, logic b);
    case (s)
      START:   return b ? S1 : START;
      S1:      return b ? S1 : S10;
      S10:     return b ? S101 : START;
      S101:    return b ? S1011 : S10;
      default: return b ? S1 : S10;
    endcase
  endfunction
endpackage

// File: rtl/seq_det_ctrl_det.sv
// seq1011_det: overlapping "1011" detector with Mealy match output
module seq1011_det
  import seq_det_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic bit_in,
  input  logic en,
  input  logic clr,
  output logic match
);
  det_t st;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= START;
    else if (clr) st <= START;
    else if (en) st <= det_next(st, bit_in);
  assign match = en && st == S101 && bit_in == PATTERN[0];
endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: round-robin arbiter feeding a serial "1011" match counter
module seq_det_ctrl
  import seq_det_ctrl_pkg::*;
#(
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req,
  input  logic [FRAME_W-1:0] data0,
  input  logic [FRAME_W-1:0] data1,
  output logic [1:0]         grant,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic [CNT_W-1:0]   hit_cnt
);
  localparam int BW = $clog2(FRAME_W + 1);
  state_t             state;
  logic [FRAME_W-1:0] sr;
  logic [BW-1:0]      cnt;
  logic [CNT_W-1:0]   acc, acc_nx;
  logic               winner, last_id, win_nx, match;
  seq1011_det u_det (
    .clk   (clk),
    .rst_n (rst_n),
    .bit_in(sr[FRAME_W-1]),
    .en    (state == SHIFT),
    .clr   (state == LOAD),
    .match (match)
  );
  assign win_nx = &req ? ~last_id : req[1];
  assign acc_nx = (match && acc != '1) ? acc + 1'b1 : acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      hit_cnt <= '0;
      acc     <= '0;
      sr      <= '0;
      cnt     <= '0;
      winner  <= 1'b0;
      last_id <= 1'b1;
    end else begin
      grant <= '0;
      done  <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          state  <= LOAD;
          busy   <= 1'b1;
          winner <= win_nx;
          grant  <= win_nx ? 2'b10 : 2'b01;
        end
        LOAD: begin
          state <= SHIFT;
          sr    <= winner ? data1 : data0;
          acc   <= '0;
          cnt   <= '0;
        end
        SHIFT: begin
          sr  <= sr << 1;
          cnt <= cnt + 1'b1;
          acc <= acc_nx;
          // acc_nx folds in the final bit's match so it is not lost
          if (cnt == BW'(FRAME_W - 1)) begin
            state   <= DONE;
            done    <= 1'b1;
            done_id <= winner;
            hit_cnt <= acc_nx;
            last_id <= winner;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: scoreboard bench with directed and random requester traffic
module tb_seq_det_ctrl;
  localparam int FW = 8;
  localparam int CW = 4;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [FW-1:0] data0 = '0, data1 = '0;
  logic [1:0]    grant;
  logic          busy, done, done_id;
  logic [CW-1:0] hit_cnt;
  seq_det_ctrl #(.FRAME_W(FW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1),
    .grant(grant), .busy(busy), .done(done), .done_id(done_id), .hit_cnt(hit_cnt)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int checks = 0, errors = 0;
  typedef struct {int id; int hit; int at;} exp_t;
  exp_t sb[$];
  exp_t e;
  bit pend[2];
  int last_id = 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic int ref_hits(logic [FW-1:0] f);
    int n = 0;
    for (int i = 0; i + 4 <= FW; i++) if (f[FW-1-i -: 4] == 4'b1011) n++;
    return n > (1 << CW) - 1 ? (1 << CW) - 1 : n;
  endfunction

  task automatic raise(input int i, input logic [FW-1:0] d);
    if (i == 1) data1 = d; else data0 = d;
    req[i] = 1'b1;
    pend[i] = 1'b1;
  endtask

  task automatic drop(input int i);
    req[i] = 1'b0;
    pend[i] = 1'b0;
  endtask

  task automatic serve(input bit hold);
    int w;
    w = (pend[0] && pend[1]) ? 1 - last_id : (pend[1] ? 1 : 0);
    for (int k = 0; k < 30 && grant == 2'b00; k++) @(negedge clk);
    chk("grant", grant, w == 1 ? 2 : 1);
    chk("busy_load", busy, 1);
    sb.push_back('{w, ref_hits(w == 1 ? data1 : data0), cyc + FW + 1});
    last_id = w;
    @(posedge clk); #1;
    if (!hold) drop(w);
  endtask

  initial forever begin
    @(negedge clk);
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("done_id", done_id, e.id);
        chk("hit_cnt", hit_cnt, e.hit);
        chk("done_latency", cyc, e.at);
      end
    end
  end

  initial begin
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    raise(0, 8'hB6); serve(0);
    raise(1, 8'h0B); serve(0);
    raise(0, 8'hB6); raise(1, 8'h5B);
    repeat (4) serve(1);
    drop(0); drop(1);
    raise(0, 8'h00); serve(0);
    raise(0, 8'hFF); serve(0);
    raise(0, 8'h5B); serve(0);
    raise(0, 8'hB6); serve(0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    void'(sb.pop_back());
    last_id = 1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_hit_cnt", hit_cnt, 0);
    chk("midrst_done", done, 0);
    chk("midrst_grant", grant, 0);
    @(negedge clk) rst_n = 1'b1;
    raise(0, 8'hB6); raise(1, 8'hFF);
    serve(0);
    repeat (40) begin
      for (int i = 0; i < 2; i++) if (!pend[i] && $urandom_range(0, 2) != 0) raise(i, FW'($urandom));
      if (!pend[0] && !pend[1]) raise(int'($urandom_range(0, 1)), FW'($urandom));
      serve(0);
      for (int j = 0; j < 2; j++)
        if (!pend[j] && $urandom_range(0, 2) == 0) begin
          raise(j, FW'($urandom));
          repeat (2) @(posedge clk);
          #1 drop(j);
        end else if (pend[j] && $urandom_range(0, 5) == 0) drop(j);
    end
    for (int k = 0; k < 40 && sb.size() > 0; k++) @(negedge clk);
    chk("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
